mopshub_test_sequencer: RTL

Synchronous controller that sequences the MOPSHUB bench phases: oscillator trim, RX test, end-of-wait pulse, inter-phase gap, TX test and custom-message test. It drives the `osc_auto_trim`, `test_rx`, `test_tx`, `test_advanced` and `endwait_all` strobes of `data_generator`/`mopshub_top`, and consumes their completion flags. It replaces ad-hoc procedural sequencing in the top-level bench with a single FSM that is timed, watchdog-protected and observable.

---
 rtl/mopshub_tb_pkg.sv | 27 ++
 rtl/seq_phase_counter.sv | 37 +++
 rtl/mopshub_test_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mopshub_tb_pkg.sv
// rtl/mopshub_tb_pkg.sv - shared state codes and defaults for the MOPSHUB test sequencer
package mopshub_tb_pkg;

   // Phase codes; these values are visible on the phase/err_phase outputs
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_TRIM    = 4'd1,
      ST_RX      = 4'd2,
      ST_ENDWAIT = 4'd3,
      ST_GAP     = 4'd4,
      ST_TX      = 4'd5,
      ST_ADV     = 4'd6,
      ST_DONE    = 4'd7,
      ST_ERR     = 4'd8
   } seq_state_t;

   // 120 cycles of the 40 MHz bench clock give the 3 us inter-phase gap
   localparam int DEF_GAP_CYCLES     = 120;
   localparam int DEF_TIMEOUT_CYCLES = 200000;
   localparam int DEF_CNT_W          = 18;

   // Phases that wait on an external completion flag and are watchdog-protected
   function automatic logic is_watched(input logic [3:0] s);
      return (s == ST_TRIM) || (s == ST_RX) || (s == ST_TX) || (s == ST_ADV);
   endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// rtl/seq_phase_counter.sv - per-phase cycle counter with gap and watchdog terminal compares
module seq_phase_counter
   import mopshub_tb_pkg::*;
#(
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
)(
   input  logic clk_40_m,
   input  logic rst,
   input  logic clr,
   output logic gap_hit,
   output logic timeout_hit
);

   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   // Count cycles since the last state entry; saturate so long idle periods never wrap into a false hit
   always_ff @(posedge clk_40_m) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   assign gap_hit     = (cnt == GAP_LAST);
   assign timeout_hit = (cnt == TO_LAST);

endmodule

// File: rtl/mopshub_test_sequencer.sv
// rtl/mopshub_test_sequencer.sv - FSM sequencing trim, RX, endwait, gap, TX and custom-message phases
module mopshub_test_sequencer
   import mopshub_tb_pkg::*;
#(
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
)(
   input  logic       clk_40_m,
   input  logic       rst,
   input  logic       start,
   input  logic       trim_en,
   input  logic       adv_en,
   input  logic       trim_done,
   input  logic       test_rx_end,
   input  logic       test_tx_end,
   input  logic       costum_msg_end,
   output logic       osc_auto_trim,
   output logic       test_rx,
   output logic       test_tx,
   output logic       test_advanced,
   output logic       endwait_all,
   output logic [3:0] phase,
   output logic       busy,
   output logic       done,
   output logic       timeout_err,
   output logic [3:0] err_phase
);

   localparam logic [3:0] S_IDLE    = ST_IDLE;
   localparam logic [3:0] S_TRIM    = ST_TRIM;
   localparam logic [3:0] S_RX      = ST_RX;
   localparam logic [3:0] S_ENDWAIT = ST_ENDWAIT;
   localparam logic [3:0] S_GAP     = ST_GAP;
   localparam logic [3:0] S_TX      = ST_TX;
   localparam logic [3:0] S_ADV     = ST_ADV;
   localparam logic [3:0] S_DONE    = ST_DONE;
   localparam logic [3:0] S_ERR     = ST_ERR;

   logic [3:0] state;
   logic [3:0] state_next;
   logic       adv_lat;
   logic       end_hit;
   logic       gap_hit;
   logic       timeout_hit;
   logic       phase_clr;
   logic       run_start;
   logic       to_err;

   // Select the completion flag that belongs to the current phase; all others are ignored
   always_comb begin
      end_hit = 1'b0;
      case (state)
         S_TRIM:  end_hit = trim_done;
         S_RX:    end_hit = test_rx_end;
         S_TX:    end_hit = test_tx_end;
         S_ADV:   end_hit = costum_msg_end;
         default: end_hit = 1'b0;
      endcase
   end

   // Completion beats a watchdog expiry landing on the same cycle
   assign to_err    = is_watched(state) && timeout_hit && !end_hit;
   assign run_start = (state == S_IDLE) && start;

   // Next-state logic; trim_en only steers the first step so it is used directly at launch
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = trim_en ? S_TRIM : S_RX;
         S_TRIM:    if (end_hit) state_next = S_RX;
                    else if (to_err) state_next = S_ERR;
         S_RX:      if (end_hit) state_next = S_ENDWAIT;
                    else if (to_err) state_next = S_ERR;
         S_ENDWAIT: state_next = S_GAP;
         S_GAP:     if (gap_hit) state_next = S_TX;
         S_TX:      if (end_hit) state_next = adv_lat ? S_ADV : S_DONE;
                    else if (to_err) state_next = S_ERR;
         S_ADV:     if (end_hit) state_next = S_DONE;
                    else if (to_err) state_next = S_ERR;
         S_DONE:    if (!start) state_next = S_IDLE;
         S_ERR:     if (!start) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Any state change restarts the phase timer
   assign phase_clr = (state_next != state);

   seq_phase_counter #(
      .GAP_CYCLES     (GAP_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_phase_counter (
      .clk_40_m    (clk_40_m),
      .rst         (rst),
      .clr         (phase_clr),
      .gap_hit     (gap_hit),
      .timeout_hit (timeout_hit)
   );

   // State register
   always_ff @(posedge clk_40_m) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Run configuration latch and sticky error capture; a new run wipes the previous error
   always_ff @(posedge clk_40_m) begin
      if (!rst) begin
         adv_lat     <= 1'b0;
         timeout_err <= 1'b0;
         err_phase   <= 4'd0;
      end else if (run_start) begin
         adv_lat     <= adv_en;
         timeout_err <= 1'b0;
         err_phase   <= 4'd0;
      end else if (to_err) begin
         timeout_err <= 1'b1;
         err_phase   <= state;
      end
   end

   assign osc_auto_trim = (state == S_TRIM);
   assign test_rx       = (state == S_RX);
   assign endwait_all   = (state == S_ENDWAIT);
   assign test_tx       = (state == S_TX);
   assign test_advanced = (state == S_ADV);
   assign done          = (state == S_DONE);
   assign busy          = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
   assign phase         = state;

endmodule
